dropout_grad_gate: RTL

Backward-pass companion to the forward dropout stage. It generates the dropout mask for one training sample, gates the forward activations, and stores the mask bit per element. It then replays the same mask on the gradient stream during backpropagation, so dropped neurons receive zero gradient. It sits between a layer's activation output and its gradient input, and is driven by the training-sequence controller.

---
 rtl/dropout_pkg.sv | 34 +++
 rtl/dropout_grad_gate_lfsr.sv | 24 ++
 rtl/dropout_grad_gate.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dropout_pkg.sv
// dropout_pkg: shared types, constants and helpers for the dropout gradient gate.
// Holds the sequencing states, the LFSR feedback taps and the saturating shift
// that implements inverted-dropout scaling.
package dropout_pkg;

    // Sample sequencing: generate mask (FWD), let the forward stage drain (HOLD),
    // then replay the mask on the gradients (BWD).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        HOLD = 2'd2,
        BWD  = 2'd3
    } state_t;

    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Arithmetic left shift of a sign-extended value, clamped to the signed
    // range of a 'width'-bit word. A shift of zero leaves in-range values untouched.
    function automatic logic signed [31:0] sat_shl(input logic signed [31:0] value,
                                                   input int shift,
                                                   input int width);
        longint wide;
        longint max_v;
        longint min_v;
        wide  = longint'(value) <<< shift;
        max_v = (longint'(1) <<< (width - 1)) - 1;
        min_v = -(longint'(1) <<< (width - 1));
        if (wide > max_v) return 32'(max_v);
        if (wide < min_v) return 32'(min_v);
        return 32'(wide);
    endfunction

endpackage

// File: rtl/dropout_grad_gate_lfsr.sv
// dropout_lfsr16: 16-bit Fibonacci LFSR that steps only when asked.
// Shifts left with the XOR of the tapped bits entering bit 0.
module dropout_lfsr16
    import dropout_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    // Step the sequence once per enabled cycle; reset is the only reseed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (advance) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/dropout_grad_gate.sv
// dropout_grad_gate: generates a per-sample dropout mask while gating forward
// activations, stores one mask bit per element, then replays that mask on the
// gradient stream so dropped neurons receive zero gradient.
// Optional build macro DROPOUT_GRAD_SCALE_EN: kept values on both paths are
// shifted left by SCALE_SHIFT with signed saturation (inverted dropout).
module dropout_grad_gate
    import dropout_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          DEPTH       = 64,
    parameter logic [15:0] DROP_THRESH = 16'h8000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          SCALE_SHIFT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    input  logic                       fwd_in_valid,
    output logic                       fwd_in_ready,
    input  logic [DATA_W-1:0]          fwd_in_data,
    output logic                       fwd_out_valid,
    input  logic                       fwd_out_ready,
    output logic [DATA_W-1:0]          fwd_out_data,
    input  logic                       bwd_in_valid,
    output logic                       bwd_in_ready,
    input  logic [DATA_W-1:0]          bwd_in_data,
    output logic                       bwd_out_valid,
    input  logic                       bwd_out_ready,
    output logic [DATA_W-1:0]          bwd_out_data,
    output logic                       len_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef DROPOUT_GRAD_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif
    // A zero shift turns the saturating path into an identity for kept values.
    localparam int EFF_SHIFT = SCALE_EN ? SCALE_SHIFT : 0;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] mask;
    logic [15:0]      lfsr;
    logic             keep;
    logic             start_ok;
    logic             fwd_fire;
    logic             bwd_fire;
    logic             cnt_last;
    logic [DATA_W-1:0] fwd_gated;
    logic [DATA_W-1:0] bwd_gated;

    dropout_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (fwd_fire),
        .value   (lfsr)
    );

    assign start_ok     = (len != '0) && (len <= CW'(DEPTH));
    assign keep         = (lfsr >= DROP_THRESH);
    assign cnt_last     = (cnt == (len_q - CW'(1)));
    assign busy         = (state != IDLE);
    assign fwd_in_ready = (state == FWD) && (!fwd_out_valid || fwd_out_ready);
    assign bwd_in_ready = (state == BWD) && (!bwd_out_valid || bwd_out_ready);
    assign fwd_fire     = fwd_in_valid && fwd_in_ready;
    assign bwd_fire     = bwd_in_valid && bwd_in_ready;

    // Gate (and optionally scale) the incoming beat on each path.
    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch forms.
        fwd_gated = '0;
        bwd_gated = '0;
        if (keep) begin
            fwd_gated = DATA_W'(sat_shl(32'($signed(fwd_in_data)), EFF_SHIFT, DATA_W));
        end
        if (mask[cnt[AW-1:0]]) begin
            bwd_gated = DATA_W'(sat_shl(32'($signed(bwd_in_data)), EFF_SHIFT, DATA_W));
        end
    end

    // Next-state logic for the sample sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && start_ok)     state_next = FWD;
            FWD:     if (fwd_fire && cnt_last)  state_next = HOLD;
            HOLD:    if (!fwd_out_valid)        state_next = BWD;
            BWD:     if (bwd_fire && cnt_last)  state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // State register, length latch, element counter, mask store and length error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
            // NOTE: the mask is a small flop array, so it is cleared on reset like any other state.
            mask    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            len_q   <= len;
                            cnt     <= '0;
                            len_err <= 1'b0;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                FWD: begin
                    if (fwd_fire) begin
                        mask[cnt[AW-1:0]] <= keep;
                        cnt               <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (!fwd_out_valid) cnt <= '0;
                end
                BWD: begin
                    if (bwd_fire) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Forward output register: load on an accepted beat, release once taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_out_valid <= 1'b0;
            fwd_out_data  <= '0;
        end else if (fwd_fire) begin
            fwd_out_valid <= 1'b1;
            fwd_out_data  <= fwd_gated;
        end else if (fwd_out_ready) begin
            fwd_out_valid <= 1'b0;
        end
    end

    // Gradient output register: load on an accepted beat, release once taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bwd_out_valid <= 1'b0;
            bwd_out_data  <= '0;
        end else if (bwd_fire) begin
            bwd_out_valid <= 1'b1;
            bwd_out_data  <= bwd_gated;
        end else if (bwd_out_ready) begin
            bwd_out_valid <= 1'b0;
        end
    end

endmodule
